mem_wb_stage: RTL and testbench

//  MEM->WB boundary of the 5-stage MIPS pipeline, directly downstream of the data memory.
//  - Captures the DM read word, ALU result, PC and destination register of the instruction in MEM.
//  - Performs sub-word load extraction (lb/lbu/lh/lhu/lw) and selects the writeback value.
//  - Presents registered writeback (GRF write port) and forwarding data to the rest of the core.

---
 rtl/mem_wb_stage_pkg.sv | 25 ++
 rtl/mem_wb_stage_load_ext.sv | 38 +++
 rtl/mem_wb_stage.sv | 89 ++++++++
 tb/tb_mem_wb_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared MIPS decode constants for the pipeline: opcodes, funct codes and the
// writeback-source select encoding.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_t;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
           (op == OP_LH) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Sub-word load extraction: picks the addressed byte/half out of a DM word
// and sign- or zero-extends it; lw passes the word through.
module load_ext
  import mips_defs::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] rd,
  output logic [31:0] ext
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rd[8*gi +: 8];
    end
  endgenerate

  // Halfword select ignores a[0]: misaligned halves are not trapped here.
  assign byte_sel = lane[a];
  assign half_sel = a[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    ext = rd;
    case (op)
      OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext = {24'h0, byte_sel};
      OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext = {16'h0, half_sel};
      default: ext = rd;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: decodes the writeback source, extracts load data,
// and presents registered GRF write-port and forwarding signals.
module mem_wb_stage
  import mips_defs::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] LINK_OFF = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [5:0]  m_op,
  input  logic [5:0]  m_func,
  input  logic [31:0] m_pc,
  input  logic [4:0]  m_a3,
  input  logic [31:0] m_alu_out,
  input  logic [31:0] m_dm_rd,
  output logic [31:0] w_pc,
  output logic [4:0]  w_a3,
  output logic [31:0] w_wd,
  output logic        w_we,
  output logic        w_is_load
);

  wb_sel_t     wb_sel;
  logic        is_load;
  logic [31:0] ext;
  logic [31:0] link;
  logic [31:0] wd_next;

  logic [31:0] w_pc_reg;
  logic [4:0]  w_a3_reg;
  logic [31:0] w_wd_reg;
  logic        w_we_reg;
  logic        w_is_load_reg;

  load_ext u_load_ext (
    .op  (m_op),
    .a   (m_alu_out[1:0]),
    .rd  (m_dm_rd),
    .ext (ext)
  );

  assign is_load = is_load_op(m_op);
  assign link    = m_pc + LINK_OFF;

  // Unknown opcodes deliberately fall through to the ALU result.
  always_comb begin
    wb_sel = WB_ALU;
    if (is_load)
      wb_sel = WB_MEM;
    else if ((m_op == OP_JAL) || ((m_op == OP_RTYPE) && (m_func == FN_JALR)))
      wb_sel = WB_LINK;
  end

  always_comb begin
    wd_next = m_alu_out;
    case (wb_sel)
      WB_MEM:  wd_next = ext;
      WB_LINK: wd_next = link;
      default: wd_next = m_alu_out;
    endcase
  end

  // Flush loads a bubble even while stalled.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      w_pc_reg      <= PC_RESET;
      w_a3_reg      <= 5'd0;
      w_wd_reg      <= 32'd0;
      w_we_reg      <= 1'b0;
      w_is_load_reg <= 1'b0;
    end else if (en) begin
      w_pc_reg      <= m_pc;
      w_a3_reg      <= m_a3;
      w_wd_reg      <= wd_next;
      w_we_reg      <= (m_a3 != 5'd0);
      w_is_load_reg <= is_load;
    end
  end

  assign w_pc      = w_pc_reg;
  assign w_a3      = w_a3_reg;
  assign w_wd      = w_wd_reg;
  assign w_we      = w_we_reg;
  assign w_is_load = w_is_load_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table followed by random traffic
// checked against a behavioural model of the writeback rules.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, en, flush;
  logic [5:0]  m_op, m_func;
  logic [31:0] m_pc, m_alu_out, m_dm_rd;
  logic [4:0]  m_a3;
  logic [31:0] w_pc, w_wd;
  logic [4:0]  w_a3;
  logic        w_we, w_is_load;

  int checks   = 0;
  int failures = 0;

  mem_wb_stage dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .m_op      (m_op),
    .m_func    (m_func),
    .m_pc      (m_pc),
    .m_a3      (m_a3),
    .m_alu_out (m_alu_out),
    .m_dm_rd   (m_dm_rd),
    .w_pc      (w_pc),
    .w_a3      (w_a3),
    .w_wd      (w_wd),
    .w_we      (w_we),
    .w_is_load (w_is_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, fl;
    logic [5:0]  op, fn;
    logic [31:0] pc;
    logic [4:0]  a3;
    logic [31:0] alu, rd;
    logic [31:0] e_pc;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_we, e_ld;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic e, input logic fl,
                              input logic [5:0] op, input logic [5:0] fn,
                              input logic [31:0] pc, input logic [4:0] a3,
                              input logic [31:0] alu, input logic [31:0] rd,
                              input logic [31:0] e_pc, input logic [4:0] e_a3,
                              input logic [31:0] e_wd, input logic e_we,
                              input logic e_ld);
    vec_t v;
    v.rst = rst; v.en = e; v.fl = fl; v.op = op; v.fn = fn; v.pc = pc;
    v.a3 = a3; v.alu = alu; v.rd = rd; v.e_pc = e_pc; v.e_a3 = e_a3;
    v.e_wd = e_wd; v.e_we = e_we; v.e_ld = e_ld;
    tbl.push_back(v);
  endfunction

  // Reference: expected GRF write data straight from the ISA load/link rules.
  function automatic logic [31:0] model_wd(input logic [5:0] op, input logic [5:0] fn,
                                           input logic [31:0] pc, input logic [31:0] alu,
                                           input logic [31:0] rd);
    logic [31:0] v;
    case (op)
      6'h23: return rd;
      6'h20, 6'h24: begin
        v = (rd >> (8 * alu[1:0])) & 32'hFF;
        if (op == 6'h20 && v >= 32'd128) v = v - 32'd256;
        return v;
      end
      6'h21, 6'h25: begin
        v = (rd >> (alu[1] ? 16 : 0)) & 32'hFFFF;
        if (op == 6'h21 && v >= 32'd32768) v = v - 32'd65536;
        return v;
      end
      6'h03: return pc + 32'd8;
      default: return (op == 6'h00 && fn == 6'h09) ? pc + 32'd8 : alu;
    endcase
  endfunction

  function automatic logic model_ld(input logic [5:0] op);
    return op == 6'h23 || op == 6'h20 || op == 6'h24 || op == 6'h21 || op == 6'h25;
  endfunction

  task automatic check(input string tag, input logic [31:0] e_pc, input logic [4:0] e_a3,
                       input logic [31:0] e_wd, input logic e_we, input logic e_ld);
    checks += 5;
    if (w_pc !== e_pc) begin
      failures++;
      $display("FAIL %s w_pc got=%h exp=%h", tag, w_pc, e_pc);
    end
    if (w_a3 !== e_a3) begin
      failures++;
      $display("FAIL %s w_a3 got=%0d exp=%0d", tag, w_a3, e_a3);
    end
    if (w_wd !== e_wd) begin
      failures++;
      $display("FAIL %s w_wd got=%h exp=%h", tag, w_wd, e_wd);
    end
    if (w_we !== e_we) begin
      failures++;
      $display("FAIL %s w_we got=%b exp=%b", tag, w_we, e_we);
    end
    if (w_is_load !== e_ld) begin
      failures++;
      $display("FAIL %s w_is_load got=%b exp=%b", tag, w_is_load, e_ld);
    end
  endtask

  task automatic drive(input logic rst, input logic e, input logic fl,
                       input logic [5:0] op, input logic [5:0] fn, input logic [31:0] pc,
                       input logic [4:0] a3, input logic [31:0] alu, input logic [31:0] rd);
    reset = rst; en = e; flush = fl; m_op = op; m_func = fn;
    m_pc = pc; m_a3 = a3; m_alu_out = alu; m_dm_rd = rd;
  endtask

  logic [5:0]  op_pool [10] = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25,
                                 6'h03, 6'h00, 6'h00, 6'h0D, 6'h3F};
  logic [31:0] x_pc, x_wd;
  logic [4:0]  x_a3;
  logic        x_we, x_ld;

  initial begin
    //   rst en fl  op     fn     pc            a3  alu           rd             e_pc          e_a3 e_wd          we ld
    add(1, 1, 0, 6'h23, 6'h00, 32'h1234_5678, 5,  32'hABCD_0001, 32'hFFFF_FFFF, 32'h3000,     0,  32'h0,        0, 0);
    add(1, 0, 1, 6'h03, 6'h09, 32'h8765_4321, 17, 32'h5555_AAAA, 32'h0F0F_0F0F, 32'h3000,     0,  32'h0,        0, 0);
    add(0, 1, 0, 6'h20, 6'h00, 32'h3004,      8,  32'h3,         32'h80FF_1234, 32'h3004,     8,  32'hFFFF_FF80, 1, 1);
    add(0, 1, 0, 6'h24, 6'h00, 32'h3008,      8,  32'h3,         32'h80FF_1234, 32'h3008,     8,  32'h0000_0080, 1, 1);
    add(0, 1, 0, 6'h20, 6'h00, 32'h300C,      8,  32'h1,         32'h80FF_1234, 32'h300C,     8,  32'h0000_0012, 1, 1);
    add(0, 1, 0, 6'h21, 6'h00, 32'h3010,      9,  32'h2,         32'h8001_7FFF, 32'h3010,     9,  32'hFFFF_8001, 1, 1);
    add(0, 1, 0, 6'h25, 6'h00, 32'h3014,      9,  32'h0,         32'h8001_7FFF, 32'h3014,     9,  32'h0000_7FFF, 1, 1);
    add(0, 1, 0, 6'h25, 6'h00, 32'h3018,      9,  32'h3,         32'h8001_7FFF, 32'h3018,     9,  32'h0000_8001, 1, 1);
    add(0, 1, 0, 6'h03, 6'h00, 32'h3010,      31, 32'hDEAD_BEEF, 32'h0,         32'h3010,     31, 32'h0000_3018, 1, 0);
    add(0, 1, 0, 6'h00, 6'h09, 32'hFFFF_FFFC, 31, 32'h1111_1111, 32'h0,         32'hFFFF_FFFC, 31, 32'h0000_0004, 1, 0);
    add(0, 1, 0, 6'h3F, 6'h00, 32'h301C,      4,  32'h0000_0077, 32'h9999_9999, 32'h301C,     4,  32'h0000_0077, 1, 0);
    add(0, 1, 0, 6'h00, 6'h21, 32'h3020,      3,  32'h0000_1234, 32'h0,         32'h3020,     3,  32'h0000_1234, 1, 0);
    add(0, 0, 0, 6'h23, 6'h00, 32'h4000,      7,  32'h0000_0001, 32'hAAAA_AAAA, 32'h3020,     3,  32'h0000_1234, 1, 0);
    add(0, 0, 0, 6'h03, 6'h00, 32'h5000,      31, 32'h0000_0002, 32'hBBBB_BBBB, 32'h3020,     3,  32'h0000_1234, 1, 0);
    add(0, 0, 0, 6'h20, 6'h00, 32'h6000,      1,  32'h0000_0003, 32'hCCCC_CCCC, 32'h3020,     3,  32'h0000_1234, 1, 0);
    add(0, 0, 1, 6'h20, 6'h00, 32'h7000,      2,  32'h0000_0003, 32'hDDDD_DDDD, 32'h3000,     0,  32'h0,        0, 0);
    add(0, 1, 0, 6'h23, 6'h00, 32'h3024,      0,  32'h0000_0005, 32'hCAFE_BABE, 32'h3024,     0,  32'hCAFE_BABE, 0, 1);
    add(1, 0, 1, 6'h23, 6'h00, 32'h3028,      6,  32'h0000_0004, 32'h1234_5678, 32'h3000,     0,  32'h0,        0, 0);
    // Same destination back-to-back: the second overwrites the first.
    add(0, 1, 0, 6'h00, 6'h21, 32'h302C,      10, 32'h0000_00AA, 32'h0,         32'h302C,     10, 32'h0000_00AA, 1, 0);
    add(0, 1, 0, 6'h00, 6'h21, 32'h3030,      10, 32'h0000_00BB, 32'h0,         32'h3030,     10, 32'h0000_00BB, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].fl, tbl[i].op, tbl[i].fn,
            tbl[i].pc, tbl[i].a3, tbl[i].alu, tbl[i].rd);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_a3, tbl[i].e_wd,
            tbl[i].e_we, tbl[i].e_ld);
      $display("vec %0d op=%h a3=%0d -> pc=%h a3=%0d wd=%h we=%b ld=%b",
               i, tbl[i].op, tbl[i].a3, w_pc, w_a3, w_wd, w_we, w_is_load);
    end

    // Random traffic; the model state follows the last table row.
    x_pc = 32'h3030; x_a3 = 5'd10; x_wd = 32'hBB; x_we = 1'b1; x_ld = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_en, r_fl;
      logic [5:0]  r_op, r_fn;
      logic [31:0] r_pc, r_alu, r_rd;
      logic [4:0]  r_a3;
      r_rst = ($urandom_range(0, 29) == 0);
      r_fl  = ($urandom_range(0, 14) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_op  = op_pool[$urandom_range(0, 9)];
      r_fn  = ($urandom_range(0, 1) == 0) ? 6'h09 : 6'($urandom);
      r_pc  = $urandom;
      r_a3  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      r_alu = $urandom;
      r_rd  = $urandom;
      drive(r_rst, r_en, r_fl, r_op, r_fn, r_pc, r_a3, r_alu, r_rd);
      if (r_rst || r_fl) begin
        x_pc = 32'h3000; x_a3 = 5'd0; x_wd = 32'h0; x_we = 1'b0; x_ld = 1'b0;
      end else if (r_en) begin
        x_pc = r_pc; x_a3 = r_a3; x_we = (r_a3 != 0);
        x_wd = model_wd(r_op, r_fn, r_pc, r_alu, r_rd);
        x_ld = model_ld(r_op);
      end
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d", i), x_pc, x_a3, x_wd, x_we, x_ld);
      $display("rnd %0d rst=%b fl=%b en=%b op=%h -> pc=%h a3=%0d wd=%h we=%b ld=%b",
               i, r_rst, r_fl, r_en, r_op, w_pc, w_a3, w_wd, w_we, w_is_load);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
